sync_fifo_ctrl: RTL and testbench

//  Parametrised single-clock FIFO; next-generation buffer for datapath staging between producer/consumer blocks.

---
 rtl/sync_fifo_ctrl.sv | 120 ++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with programmable thresholds, occupancy,
// sticky error flags and optional first-word-fall-through read.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   wr_en, din        write request and data
//   rd_en             read request (FWFT: pop head)
//   dout, dout_valid  read data and its qualifier
//   full, empty       occupancy == DEPTH / == 0
//   almost_full       count >= AF_LEVEL
//   almost_empty      count <= AE_LEVEL
//   count             occupancy 0..DEPTH
//   overflow          sticky: a write was rejected
//   underflow         sticky: a read was rejected
//   clr_err           synchronous clear of both error flags
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      din,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       dout_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          rd_acc, wr_acc;

  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // A full FIFO still takes a write when a read frees a slot
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case (1'b1)
      wr_acc & ~rd_acc: count_d = count_q + CW'(1);
      rd_acc & ~wr_acc: count_d = count_q - CW'(1);
      default:          count_d = count_q;
    endcase
    // A new error outranks a clear in the same cycle
    ovf_d = (ovf_q & ~clr_err) | (wr_en & ~wr_acc);
    unf_d = (unf_q & ~clr_err) | (rd_en & ~rd_acc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= din;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented directly from storage
    assign dout       = mem[rd_ptr_q];
    assign dout_valid = ~empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q   <= '0;
        dvalid_q <= 1'b0;
      end else begin
        dvalid_q <= rd_acc;
        if (rd_acc) dout_q <= mem[rd_ptr_q];
      end
    end

    assign dout       = dout_q;
    assign dout_valid = dvalid_q;
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed testbench for sync_fifo_ctrl.
// Standard-mode and FWFT instances share clock and reset.
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       dv, full, empty, af, ae, ovf, unf;
  logic [4:0] count;

  logic       fwr = 1'b0, frd = 1'b0, fclr = 1'b0;
  logic [7:0] fdin = '0;
  logic [7:0] fdout;
  logic       fdv, ffull, fempty, faf, fae, fovf, funf;
  logic [4:0] fcount;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din),
    .rd_en(rd_en), .dout(dout), .dout_valid(dv),
    .full(full), .empty(empty), .almost_full(af),
    .almost_empty(ae), .count(count), .overflow(ovf),
    .underflow(unf), .clr_err(clr_err)
  );

  sync_fifo_ctrl #(.FWFT(1)) u_fw (
    .clk(clk), .rst_n(rst_n), .wr_en(fwr), .din(fdin),
    .rd_en(frd), .dout(fdout), .dout_valid(fdv),
    .full(ffull), .empty(fempty), .almost_full(faf),
    .almost_empty(fae), .count(fcount), .overflow(fovf),
    .underflow(funf), .clr_err(fclr)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if ({empty, full, ae, af} !== 4'b1010) begin bad++; $display("FAIL rst_flags got=%b exp=1010", {empty, full, ae, af}); end
    total++; if ({dv, ovf, unf} !== 3'b000) begin bad++; $display("FAIL rst_dv_err got=%b exp=000", {dv, ovf, unf}); end
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL rst_dout got=%0h exp=0", dout); end
    total++; if ({fempty, fdv} !== 2'b10) begin bad++; $display("FAIL rst_fwft got=%b exp=10", {fempty, fdv}); end
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; din = 8'(i);
      step;
      total++; if (count !== 5'(i)) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", count, i); end
      total++; if (af !== (i >= 12)) begin bad++; $display("FAIL fill_af i=%0d got=%b exp=%b", i, af, i >= 12); end
      total++; if (full !== (i == 16)) begin bad++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, full, i == 16); end
    end
    din = 8'hAA;
    step;
    wr_en = 1'b0;
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL fill_ovf got=%b exp=1", ovf); end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL fill_ovf_count got=%0d exp=16", count); end
  endtask

  task automatic test_drain;
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1'b1;
      step;
      total++; if (dv !== 1'b1) begin bad++; $display("FAIL drain_dv i=%0d got=%b exp=1", i, dv); end
      total++; if (dout !== 8'(i)) begin bad++; $display("FAIL drain_data got=%0h exp=%0h", dout, i); end
      total++; if (count !== 5'(16 - i)) begin bad++; $display("FAIL drain_count got=%0d exp=%0d", count, 16 - i); end
      total++; if (ae !== (16 - i <= 2)) begin bad++; $display("FAIL drain_ae i=%0d got=%b", i, ae); end
      total++; if (empty !== (i == 16)) begin bad++; $display("FAIL drain_empty i=%0d got=%b", i, empty); end
    end
    step;
    rd_en = 1'b0;
    total++; if (unf !== 1'b1) begin bad++; $display("FAIL drain_unf got=%b exp=1", unf); end
    total++; if (dv !== 1'b0) begin bad++; $display("FAIL drain_extra_dv got=%b exp=0", dv); end
    total++; if (dout !== 8'h10) begin bad++; $display("FAIL drain_hold got=%0h exp=10", dout); end
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
    total++; if ({ovf, unf} !== 2'b00) begin bad++; $display("FAIL drain_clr got=%b exp=00", {ovf, unf}); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; din = 8'(8'h20 + i);
      step;
    end
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; din = 8'(8'h28 + i);
      step;
      total++; if (count !== 5'd8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", count); end
      total++; if (dv !== 1'b1 || dout !== 8'(8'h20 + i)) begin bad++; $display("FAIL b2b_data got=%0h exp=%0h", dout, 8'h20 + i); end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step;
      total++; if (dout !== 8'(8'h34 + i)) begin bad++; $display("FAIL b2b_tail got=%0h exp=%0h", dout, 8'h34 + i); end
    end
    rd_en = 1'b0;
    step;
    total++; if ({empty, ovf, unf} !== 3'b100) begin bad++; $display("FAIL b2b_end got=%b exp=100", {empty, ovf, unf}); end
  endtask

  task automatic test_full_pass;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; din = 8'(8'h40 + i);
      step;
    end
    rd_en = 1'b1; din = 8'h99;
    step;
    wr_en = 1'b0; rd_en = 1'b0;
    total++; if (count !== 5'd16 || full !== 1'b1) begin bad++; $display("FAIL pass_count got=%0d exp=16", count); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL pass_ovf got=%b exp=0", ovf); end
    total++; if (dv !== 1'b1 || dout !== 8'h40) begin bad++; $display("FAIL pass_data got=%0h exp=40", dout); end
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1'b1;
      step;
      total++; if (dout !== ((i == 16) ? 8'h99 : 8'(8'h40 + i))) begin bad++; $display("FAIL pass_drain i=%0d got=%0h", i, dout); end
    end
    rd_en = 1'b0;
    step;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL pass_empty got=%b exp=1", empty); end
  endtask

  task automatic test_fwft;
    fwr = 1'b1; fdin = 8'h5A;
    step;
    fwr = 1'b0;
    total++; if (fdv !== 1'b1 || fdout !== 8'h5A) begin bad++; $display("FAIL fwft_head got=%0h dv=%b exp=5a", fdout, fdv); end
    total++; if (fempty !== 1'b0) begin bad++; $display("FAIL fwft_nempty got=%b exp=0", fempty); end
    frd = 1'b1;
    step;
    frd = 1'b0;
    total++; if ({fempty, fdv} !== 2'b10) begin bad++; $display("FAIL fwft_pop got=%b exp=10", {fempty, fdv}); end
    total++; if (funf !== 1'b0) begin bad++; $display("FAIL fwft_unf got=%b exp=0", funf); end
  endtask

  task automatic test_reset_clear;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; din = 8'(8'h61 + i);
      step;
    end
    wr_en = 1'b0; rd_en = 1'b1;
    step;
    total++; if (count !== 5'd5 || dv !== 1'b1 || dout !== 8'h61) begin bad++; $display("FAIL mid_pre count=%0d dout=%0h exp=5,61", count, dout); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (count !== 5'd0 || {empty, full, ae, af} !== 4'b1010) begin bad++; $display("FAIL mid_rst count=%0d flags=%b", count, {empty, full, ae, af}); end
    total++; if (dv !== 1'b0 || dout !== 8'h00) begin bad++; $display("FAIL mid_rst_dout got=%0h dv=%b exp=0", dout, dv); end
    rd_en = 1'b0;
    step;
    rst_n = 1'b1;
    step;
    total++; if (dv !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL mid_release dv=%b empty=%b", dv, empty); end
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; din = 8'(i);
      step;
    end
    step;
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL clr_set got=%b exp=1", ovf); end
    clr_err = 1'b1;
    step;
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL clr_collide got=%b exp=1", ovf); end
    wr_en = 1'b0;
    step;
    clr_err = 1'b0;
    total++; if (ovf !== 1'b0 || count !== 5'd16) begin bad++; $display("FAIL clr_alone ovf=%b count=%0d", ovf, count); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_drain;
    test_back_to_back;
    test_full_pass;
    test_fwft;
    test_reset_clear;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
